period_abs_sum_ctrl: RTL and testbench

- Sequences the shared 16-lane int8 absolute-sum datapath across a detection period of N 128-bit beats.
- Feeds each accepted beat to the datapath and accumulates the per-beat sums into a period energy.
- Compares the energy against a threshold and reports energy plus a detect flag over a valid/ready output handshake.
- Sits between the sample stream and the detection decision logic.

---
 rtl/period_abs_sum_ctrl.sv | 151 +++++++++++++++
 tb/tb_period_abs_sum_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_abs_sum_ctrl.sv
// period_abs_sum_ctrl
//
// Runs the shared 16-lane int8 absolute-sum datapath over one detection
// period of cfg_beats 128-bit beats. Each accepted beat goes into dp_data,
// and the datapath's sum is added to a saturating energy accumulator one
// cycle later. At the end of the period the energy and a threshold decision
// are offered on a valid/ready report port. The block then either idles or,
// in continuous mode, starts the next period.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        run control pulses (abort wins over everything)
//   cfg_beats           beats per period, 0 = 2^BEATS_W (latched on start)
//   cfg_thresh          detection threshold (latched on start)
//   cfg_cont            1 = back-to-back periods until abort (latched on start)
//   in_valid/in_ready   input beat handshake, in_data = 16 x int8
//   dp_data / dp_sum    registered beat to the datapath and its abs-sum
//   out_valid/out_ready report handshake
//   out_energy          period energy, out_detect = energy >= threshold
//   busy                any state other than IDLE
`timescale 1ns/1ps
module period_abs_sum_ctrl #(
    parameter int BEATS_W = 8,
    parameter int ACC_W   = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BEATS_W-1:0] cfg_beats,
    input  logic [ACC_W-1:0]   cfg_thresh,
    input  logic               cfg_cont,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    output logic [127:0]       dp_data,
    input  logic [31:0]        dp_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_energy,
    output logic               out_detect,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

    state_t             state_reg, state_next;
    logic [BEATS_W-1:0] cfg_beats_reg;
    logic [ACC_W-1:0]   cfg_thresh_reg;
    logic               cfg_cont_reg;
    logic [BEATS_W-1:0] cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               s1_reg;

    logic               handshake;
    logic [BEATS_W-1:0] cnt_inc;
    logic               last_beat;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_add;
    logic [ACC_W-1:0]   acc_next;
    logic               unused_dp_sum_hi;

    // A per-beat sum never exceeds 2048, so only the low 12 bits matter.
    assign unused_dp_sum_hi = ^dp_sum[31:12];

    assign handshake = in_valid & in_ready;
    assign cnt_inc   = cnt_reg + 1'b1;
    // The counter wraps naturally, so cfg_beats = 0 matches after 2^BEATS_W
    // beats without any special case.
    assign last_beat = (cnt_inc == cfg_beats_reg);

    // One extra bit catches the carry; on overflow the accumulator pins at
    // all-ones instead of wrapping.
    assign acc_sum  = {1'b0, acc_reg} + {{(ACC_W-11){1'b0}}, dp_sum[11:0]};
    assign acc_add  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign acc_next = s1_reg ? acc_add : acc_reg;

    assign out_valid = (state_reg == REPORT);
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_next = DRAIN;
            end
            DRAIN:   state_next = REPORT;
            REPORT:  if (out_ready) state_next = cfg_cont_reg ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cfg_beats_reg  <= '0;
            cfg_thresh_reg <= '0;
            cfg_cont_reg   <= 1'b0;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            s1_reg         <= 1'b0;
            dp_data        <= '0;
            out_energy     <= '0;
            out_detect     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (abort) begin
                // Partial period and any pending report are thrown away.
                s1_reg  <= 1'b0;
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                s1_reg  <= handshake;
                acc_reg <= acc_next;
                if (handshake) begin
                    dp_data <= in_data;
                    cnt_reg <= cnt_inc;
                end
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            cfg_beats_reg  <= cfg_beats;
                            cfg_thresh_reg <= cfg_thresh;
                            cfg_cont_reg   <= cfg_cont;
                            acc_reg        <= '0;
                            cnt_reg        <= '0;
                        end
                    end
                    DRAIN: begin
                        // The final beat's sum lands on this edge, so the
                        // report captures the post-add value.
                        out_energy <= acc_next;
                        out_detect <= (acc_next >= cfg_thresh_reg);
                    end
                    REPORT: begin
                        if (out_ready) begin
                            acc_reg <= '0;
                            cnt_reg <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_abs_sum_ctrl.sv
`timescale 1ns/1ps
module tb_period_abs_sum_ctrl;
    localparam int BW = 8;
    localparam int AW = 40;
    localparam int AW12 = 12;
    localparam longint MAXE = (64'd1 << AW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start12 = 1'b0, abort = 1'b0;
    logic [BW-1:0] cfg_beats = '0;
    logic [AW-1:0] cfg_thresh = '0;
    logic [AW12-1:0] cfg_thresh12 = '0;
    logic cfg_cont = 1'b0;
    logic in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic out_ready = 1'b0;

    logic in_ready, out_valid, out_detect, busy;
    logic [127:0] dp_data;
    logic [31:0] dp_sum;
    logic [AW-1:0] out_energy;
    logic in_ready12, out_valid12, out_detect12, busy12;
    logic [127:0] dp_data12;
    logic [31:0] dp_sum12;
    logic [AW12-1:0] out_energy12;

    always #5 clk = ~clk;

    function automatic logic [31:0] absum(input logic [127:0] d);
        int s;
        logic signed [7:0] b;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            b = d[8*i +: 8];
            s += (b < 0) ? -int'(b) : int'(b);
        end
        return 32'(s);
    endfunction

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    // Behavioural datapath stand-in
    assign dp_sum   = absum(dp_data);
    assign dp_sum12 = absum(dp_data12);

    period_abs_sum_ctrl #(.BEATS_W(BW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_beats(cfg_beats), .cfg_thresh(cfg_thresh), .cfg_cont(cfg_cont),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_data(dp_data), .dp_sum(dp_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_energy(out_energy), .out_detect(out_detect), .busy(busy)
    );

    period_abs_sum_ctrl #(.BEATS_W(BW), .ACC_W(AW12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort),
        .cfg_beats(cfg_beats), .cfg_thresh(cfg_thresh12), .cfg_cont(cfg_cont),
        .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data),
        .dp_data(dp_data12), .dp_sum(dp_sum12),
        .out_valid(out_valid12), .out_ready(out_ready),
        .out_energy(out_energy12), .out_detect(out_detect12), .busy(busy12)
    );

    int nvec = 0;
    int nfail = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- period model (main instance) ----------------
    bit     m_active, m_wait, m_cont;
    int     m_n, m_cnt;
    longint m_sum, m_thr, m_due;
    longint q_e[$];
    bit     q_d[$];

    task automatic model_clear();
        m_active = 0; m_wait = 0; m_cnt = 0; m_sum = 0; m_due = -1;
        q_e.delete(); q_d.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            if (abort) begin
                model_clear();
            end else begin
                if (start && !m_active) begin
                    m_active = 1; m_wait = 0;
                    m_n = (cfg_beats == 0) ? 256 : int'(cfg_beats);
                    m_thr = longint'(cfg_thresh);
                    m_cont = cfg_cont;
                    m_cnt = 0; m_sum = 0;
                end
                if (in_valid && in_ready) begin
                    nvec++;
                    if (!m_active || m_wait) begin
                        nfail++;
                        $display("FAIL accept: beat taken while not accumulating (t=%0t)", $time);
                    end else begin
                        m_sum = m_sum + longint'(absum(in_data));
                        if (m_sum > MAXE) m_sum = MAXE;
                        m_cnt++;
                        if (m_cnt == m_n) begin
                            q_e.push_back(m_sum);
                            q_d.push_back(m_sum >= m_thr);
                            m_due = cyc + 2;
                            m_wait = 1; m_cnt = 0; m_sum = 0;
                        end
                    end
                end
                if (out_valid && out_ready && q_e.size() > 0) begin
                    void'(q_e.pop_front());
                    void'(q_d.pop_front());
                    m_wait = 0;
                    if (!m_cont) m_active = 0;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = rst_n && (q_e.size() > 0) && (cyc >= m_due);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("busy", 64'(busy), 64'(rst_n && m_active));
        if (ev && out_valid) begin
            chk("out_energy", 64'(out_energy), 64'(q_e[0]));
            chk("out_detect", 64'(out_detect), 64'(q_d[0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input bit which, input int n, input longint thr, input bit cont);
        @(posedge clk); #1;
        cfg_beats = BW'(n);
        cfg_cont = cont;
        if (which) begin cfg_thresh12 = AW12'(thr); start12 = 1; end
        else begin cfg_thresh = AW'(thr); start = 1; end
        @(posedge clk); #1;
        start = 0; start12 = 0;
        // Scramble config: only the latched copy may matter now.
        cfg_beats = 8'hff; cfg_thresh = '1; cfg_thresh12 = '0; cfg_cont = ~cont;
    endtask

    task automatic send_beat(input bit which, input logic [127:0] d, output int stalls);
        in_data = d;
        in_valid = 1;
        stalls = 0;
        while (!(which ? in_ready12 : in_ready) && stalls < 100) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 100) chk("beat_timeout", 64'(stalls), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input bit which);
        int t;
        t = 0;
        @(negedge clk);
        while (!(which ? out_valid12 : out_valid) && t < 700) begin
            @(negedge clk);
            t++;
        end
        chk("report_timeout", 64'(t >= 700), 64'(0));
    endtask

    initial begin
        int st, tot;
        logic [127:0] alt;
        alt = {8{8'h81, 8'h7f}};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_energy", 64'(out_energy), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_dp_data", 64'(dp_data != 0), 64'(0));
        rst_n = 1;

        // 1: two beats +1 / -1, one-shot, latency check
        out_ready = 1;
        start_run(0, 2, 100, 0);
        send_beat(0, rep(8'h01), st);
        send_beat(0, rep(8'hff), st);
        in_valid = 0;
        @(negedge clk);
        chk("t1_valid_early", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("t1_valid_t2", 64'(out_valid), 64'(1));
        chk("t1_energy", 64'(out_energy), 64'(32));
        chk("t1_detect", 64'(out_detect), 64'(0));
        @(posedge clk); #1;
        chk("t1_idle", 64'(busy), 64'(0));

        // 2: four beats of -128, equality detect, held report
        out_ready = 0;
        start_run(0, 4, 8192, 0);
        for (int i = 0; i < 4; i++) send_beat(0, rep(8'h80), st);
        in_valid = 0;
        wait_valid(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 64'(out_valid), 64'(1));
            chk("t2_energy", 64'(out_energy), 64'(8192));
            chk("t2_detect", 64'(out_detect), 64'(1));
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        chk("t2_idle", 64'(busy), 64'(0));

        // 3: continuous periods of 3 beats of +2, then abort mid-period
        start_run(0, 3, 97, 1);
        tot = 0;
        for (int i = 0; i < 9; i++) begin
            send_beat(0, rep(8'h02), st);
            tot += st;
        end
        chk("t3_stalls", 64'(tot), 64'(4));
        send_beat(0, rep(8'h02), st);
        chk("t3_stall_p4", 64'(st), 64'(2));
        in_valid = 0;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        chk("t3_abort_idle", 64'(busy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_no_report", 64'(out_valid), 64'(0));
        end

        // 4: ACC_W=12 instance, 256 beats of -128, saturation
        start_run(1, 0, 4095, 0);
        for (int i = 0; i < 256; i++) send_beat(1, rep(8'h80), st);
        in_valid = 0;
        wait_valid(1);
        chk("t4_energy", 64'(out_energy12), 64'(4095));
        chk("t4_detect", 64'(out_detect12), 64'(1));
        @(posedge clk); #1;
        chk("t4_idle", 64'(busy12), 64'(0));

        // 5: gapped input, alternating +127/-127, start pulses ignored
        start_run(0, 5, 10161, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 0;
            start = 1;
            @(posedge clk); #1;
            start = 0;
            @(posedge clk); #1;
            send_beat(0, alt, st);
        end
        in_valid = 0;
        wait_valid(0);
        chk("t5_energy", 64'(out_energy), 64'(10160));
        chk("t5_detect", 64'(out_detect), 64'(0));
        @(posedge clk); #1;
        chk("t5_idle", 64'(busy), 64'(0));

        // 6: async reset during REPORT, then a fresh run
        out_ready = 0;
        start_run(0, 1, 1, 0);
        send_beat(0, rep(8'h01), st);
        in_valid = 0;
        wait_valid(0);
        #2 rst_n = 0;
        #0.5;
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_energy", 64'(out_energy), 64'(0));
        chk("t6_rst_detect", 64'(out_detect), 64'(0));
        chk("t6_rst_dp", 64'(dp_data != 0), 64'(0));
        #0.5 rst_n = 1;
        out_ready = 1;
        start_run(0, 2, 32, 0);
        send_beat(0, rep(8'h01), st);
        send_beat(0, rep(8'hff), st);
        in_valid = 0;
        wait_valid(0);
        chk("t6_energy", 64'(out_energy), 64'(32));
        chk("t6_detect", 64'(out_detect), 64'(1));
        @(posedge clk); #1;
        chk("t6_idle", 64'(busy), 64'(0));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
